// File: rtl/seg_dec_pkg.sv
// Shared 7-segment definitions: pattern constants (gfedcba, active-high),
// the pattern-to-nibble decoder, and the frame assembler state type.
package seg_dec_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {COLLECT, HOLD} state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] nib;
  } seg_dec_t;

  // Unknown patterns decode to nibble 0 with err set.
  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t r;
    r = '0;
    case (pat)
      SEG_0:   r.nib = 4'h0;
      SEG_1:   r.nib = 4'h1;
      SEG_2:   r.nib = 4'h2;
      SEG_3:   r.nib = 4'h3;
      SEG_4:   r.nib = 4'h4;
      SEG_5:   r.nib = 4'h5;
      SEG_6:   r.nib = 4'h6;
      SEG_7:   r.nib = 4'h7;
      SEG_8:   r.nib = 4'h8;
      SEG_9:   r.nib = 4'h9;
      SEG_A:   r.nib = 4'hA;
      SEG_B:   r.nib = 4'hB;
      SEG_C:   r.nib = 4'hC;
      SEG_D:   r.nib = 4'hD;
      SEG_E:   r.nib = 4'hE;
      SEG_F:   r.nib = 4'hF;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Input register and stability qualifier: emits one capture pulse once the
// same one-hot {an, seg} sample has been seen STABLE_CYCLES times in a row.
module seg_stable_filter #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg_i,
  input  logic [DIGITS-1:0] an_i,
  output logic              cap_o,
  output logic [DIGITS-1:0] cap_an_o,
  output logic [6:0]        cap_seg_o
);

  localparam int SW = DIGITS + 7;
  // The incoming sample is compared against the registered one, so the
  // S-th identical sample fires the pulse while it is being registered.
  localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 2);

  logic [SW-1:0] sample;
  logic [SW-1:0] in_q;
  logic [7:0]    run_q, run_d;
  logic          done_q, done_d;
  logic          cap;

  assign sample = {an_i, seg_i};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    run_d  = '0;
    done_d = 1'b0;
    cap    = 1'b0;
    if ((sample == in_q) && $onehot(an_i)) begin
      run_d  = run_q;
      done_d = done_q;
      if (!done_q) begin
        if (run_q == RUN_LAST) begin
          cap    = 1'b1;
          done_d = 1'b1;
        end else begin
          run_d = run_q + 8'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q   <= '0;
      run_q  <= '0;
      done_q <= 1'b0;
    end else begin
      in_q   <= sample;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign cap_o     = cap;
  assign cap_an_o  = in_q[SW-1:7];
  assign cap_seg_o = in_q[6:0];

endmodule

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment bus receiver: assembles decoded digits into a frame
// offered on valid/ready. Define SEGDEC_DROP_CNT_EN to add the drop_cnt port.
module seg_scan_decoder
  import seg_dec_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg,
  input  logic [DIGITS-1:0]   an,
  output logic [4*DIGITS-1:0] out_value,
  output logic [DIGITS-1:0]   out_err,
  output logic                out_valid,
  input  logic                out_ready
`ifdef SEGDEC_DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  logic              cap;
  logic [DIGITS-1:0] cap_an;
  logic [6:0]        cap_seg;
  seg_dec_t          cap_dec;

  state_t              state_q, state_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                wr;

  seg_stable_filter #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .seg_i    (seg),
    .an_i     (an),
    .cap_o    (cap),
    .cap_an_o (cap_an),
    .cap_seg_o(cap_seg)
  );

  assign cap_dec = seg_decode(cap_seg);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    value_d = value_q;
    err_d   = err_q;
    wr      = 1'b0;
    case (state_q)
      COLLECT: begin
        wr = cap;
        if (cap) mask_d = mask_q | cap_an;
        if (&mask_q) state_d = HOLD;
      end
      HOLD: begin
        // A capture landing on the handshake cycle seeds the next frame.
        if (out_ready) begin
          state_d = COLLECT;
          wr      = cap;
          mask_d  = cap ? cap_an : '0;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (wr) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_an[i]) begin
          value_d[4*i +: 4] = cap_dec.nib;
          err_d[i]          = cap_dec.err;
        end
      end
    end
  end

  // NOTE: slot registers are reset too, so a reset mid-frame leaves no stale digits visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      mask_q  <= '0;
      value_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_value = value_q;
  assign out_err   = err_q;

`ifdef SEGDEC_DROP_CNT_EN
  logic       discard;
  logic [7:0] drop_q;

  assign discard = cap && (state_q == HOLD) && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (discard && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=8); the drop
// counter is checked when SEGDEC_DROP_CNT_EN is defined.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] out_value;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
`ifdef SEGDEC_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .DIGITS       (4),
    .STABLE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seg      (seg),
    .an       (an),
    .out_value(out_value),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SEGDEC_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a sample at a falling edge and keep it for n cycles.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = 4'b0000;
    seg = 7'h00;
    step(2);
    rst = 1'b0;
  endtask

  task automatic check_drop(input string tag, input logic [7:0] exp);
`ifdef SEGDEC_DROP_CNT_EN
    check(tag, drop_cnt, exp);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    an        = 4'b0000;
    seg       = 7'h00;
    out_ready = 1'b0;
    step(3);
    rst = 1'b0;

    check("rst_value", out_value, 16'h0000);
    check("rst_err",   out_err,   4'h0);
    check("rst_valid", out_valid, 1'b0);
    check_drop("rst_drop", 8'd0);

    // Basic scan 0,1,2,3 with the consumer always ready.
    out_ready = 1'b1;
    hold(4'b0001, 7'h3F, 8);
    hold(4'b0010, 7'h06, 8);
    check("scan_partial1", out_value, 16'h0010);
    hold(4'b0100, 7'h5B, 8);
    check("scan_partial2", out_value, 16'h0210);
    hold(4'b1000, 7'h4F, 8);
    check("scan_valid_lag", out_valid, 1'b0);
    step(1);
    check("scan_valid", out_valid, 1'b1);
    check("scan_value", out_value, 16'h3210);
    check("scan_err",   out_err,   4'h0);
    step(1);
    check("scan_pulse_end", out_valid, 1'b0);

    // Seven samples are one short of a capture; eight succeed.
    hold(4'b0001, 7'h6D, 7);
    check("short_hold", out_value, 16'h3210);
    hold(4'b0000, 7'h00, 2);
    check("short_hold_gap", out_value, 16'h3210);
    hold(4'b0001, 7'h6D, 8);
    check("full_hold", out_value, 16'h3215);

    // Non-hex pattern on digit 2.
    hold(4'b0100, 7'h00, 8);
    check("err_value", out_value, 16'h3015);
    check("err_bits",  out_err,   4'b0100);
    hold(4'b0010, 7'h06, 8);
    hold(4'b1000, 7'h4F, 8);
    check("err_valid_lag", out_valid, 1'b0);
    step(1);
    check("err_frame_valid", out_valid, 1'b1);
    check("err_frame_value", out_value, 16'h3015);
    check("err_frame_err",   out_err,   4'b0100);
    step(1);
    check("err_frame_done", out_valid, 1'b0);
    out_ready = 1'b0;

    // Strobes that are not one-hot never capture.
    hold(4'b0011, 7'h3F, 20);
    hold(4'b1100, 7'h79, 20);
    hold(4'b0000, 7'h3F, 20);
    check("onehot_value", out_value, 16'h3015);
    check("onehot_err",   out_err,   4'b0100);
    check("onehot_valid", out_valid, 1'b0);

    // Frame FEDC with a stalled consumer.
    hold(4'b0001, 7'h39, 8);
    hold(4'b0010, 7'h5E, 8);
    hold(4'b0100, 7'h79, 8);
    check("fedc_partial_valid", out_valid, 1'b0);
    check("fedc_partial_value", out_value, 16'h3EDC);
    check("fedc_partial_err",   out_err,   4'h0);
    hold(4'b1000, 7'h71, 8);
    step(1);
    check("fedc_valid", out_valid, 1'b1);
    check("fedc_value", out_value, 16'hFEDC);

    hold(4'b0001, 7'h3F, 8);
    hold(4'b0010, 7'h06, 8);
    hold(4'b0100, 7'h5B, 8);
    hold(4'b1000, 7'h4F, 8);
    check("stall_valid", out_valid, 1'b1);
    check("stall_value", out_value, 16'hFEDC);
    check("stall_err",   out_err,   4'h0);
    check_drop("stall_drop", 8'd4);

    out_ready = 1'b1;
    step(1);
    check("stall_release", out_valid, 1'b0);
    out_ready = 1'b0;
    hold(4'b0001, 7'h3F, 8);
    hold(4'b0010, 7'h06, 8);
    hold(4'b0100, 7'h5B, 8);
    check("mask_cleared_valid", out_valid, 1'b0);
    check("mask_cleared_value", out_value, 16'hF210);
    check_drop("drop_kept", 8'd4);

    // Reset mid-frame after two captures, then a fresh full scan.
    do_reset();
    check_drop("drop_after_rst", 8'd0);
    hold(4'b1000, 7'h77, 8);
    hold(4'b0100, 7'h7C, 8);
    check("pre_rst_value", out_value, 16'hAB00);
    do_reset();
    check("midrst_value", out_value, 16'h0000);
    check("midrst_err",   out_err,   4'h0);
    check("midrst_valid", out_valid, 1'b0);
    hold(4'b0001, 7'h7D, 8);
    hold(4'b0010, 7'h07, 8);
    hold(4'b0100, 7'h7F, 8);
    step(1);
    check("fresh_partial_valid", out_valid, 1'b0);
    hold(4'b1000, 7'h6F, 8);
    check("fresh_valid_lag", out_valid, 1'b0);
    step(1);
    check("fresh_valid", out_valid, 1'b1);
    check("fresh_value", out_value, 16'h9876);
    check("fresh_err",   out_err,   4'h0);
    out_ready = 1'b1;
    step(1);
    check("fresh_done", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
